booth_mult_param: RTL

Parametrised sequential radix-2 Booth multiplier. It generalises the fixed 16-bit multiplier to any operand width and adds a per-operation signed/unsigned mode, a completion pulse, a registered result hold, and a synchronous abort. It sits beside the control/odometry datapath and serves any block needing an NxN multiply at one Booth step per clock.

---
 rtl/booth_mult_param_if.sv | 24 ++
 rtl/booth_mult_param.sv | 108 ++++++++++
 2 files changed

// File: rtl/booth_mult_param_if.sv
// Handshake/bus bundle for the parametrised Booth multiplier.
// The requester drives the operands and the multiplier returns status and product.
interface booth_mult_param_if #(
  parameter int WIDTH = 16
);
  logic               en;
  logic               abort;
  logic               sgn;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] R;

  modport master (
    output en, abort, sgn, A, B,
    input  busy, done, R
  );

  modport slave (
    input  en, abort, sgn, A, B,
    output busy, done, R
  );
endinterface

// File: rtl/booth_mult_param.sv
// Sequential radix-2 Booth multiplier, one step per clock,
// with signed/unsigned mode, done pulse, held result and abort.
module booth_mult_param #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst,
  booth_mult_param_if.slave bus
);
  localparam int XW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [XW-1:0]      m;
  logic [XW-1:0]      u;
  logic [XW-1:0]      q;
  logic               qm1;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] r_q;

  logic [XW-1:0]      a_ext;
  logic [XW-1:0]      b_ext;
  logic [XW:0]        u_x;
  logic [XW:0]        m_x;
  logic [XW:0]        sum;
  logic               add_op;
  logic               sub_op;

  // Top bit is a sign copy only in signed mode.
  assign a_ext = {bus.sgn & bus.A[WIDTH-1], bus.A};
  assign b_ext = {bus.sgn & bus.B[WIDTH-1], bus.B};

  assign u_x    = {u[XW-1], u};
  assign m_x    = {m[XW-1], m};
  assign add_op = ~q[0] & qm1;
  assign sub_op = q[0] & ~qm1;

  always_comb begin
    sum = u_x;
    unique case (1'b1)
      add_op:  sum = u_x + m_x;
      sub_op:  sum = u_x - m_x;
      default: sum = u_x;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      m      <= '0;
      u      <= '0;
      q      <= '0;
      qm1    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      r_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.en) begin
            m      <= b_ext;
            q      <= a_ext;
            u      <= '0;
            qm1    <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            // Arithmetic right shift of {sum, q, qm1} by one.
            u   <= sum[XW:1];
            q   <= {sum[0], q[XW-1:1]};
            qm1 <= q[0];
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH))
              state <= DONE;
          end
        end
        DONE: begin
          r_q    <= {u[WIDTH-2:0], q};
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.R    = r_q;
endmodule
